// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, one memory read per instruction, word+PC handed to decode. Latency: mem_ready -> instr_valid 1 cycle.
// Backpressure: stalls in HOLD until decode_ready; chip_enabled low freezes all state; taken branches drop in-flight or held work.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  chip_enabled,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [LEN-1:0]        mem_data,
    output logic                  instr_valid,
    output logic [LEN-1:0]        instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  decode_ready,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [LEN-1:0]        instr_q, instr_d;
    logic                  discard_q, discard_d;

    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] restart_addr;

    assign target       = branch_target & ~ADDR_WIDTH'(3);
    assign restart_addr = branch_taken ? target : pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            req_addr_q <= '0;
            instr_pc_q <= '0;
            instr_q    <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
            discard_q  <= discard_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        discard_d  = discard_q;
        if (chip_enabled) begin
            case (state_q)
                S_IDLE: begin
                    pc_d       = restart_addr;
                    req_addr_d = restart_addr;
                    state_d    = S_FETCH;
                end
                S_FETCH: begin
                    // The bus transaction always runs to completion; a redirect only marks its data stale.
                    if (mem_ready) begin
                        if (discard_q || branch_taken) begin
                            discard_d  = 1'b0;
                            pc_d       = restart_addr;
                            req_addr_d = restart_addr;
                        end else begin
                            instr_d    = mem_data;
                            instr_pc_d = req_addr_q;
                            pc_d       = req_addr_q + ADDR_WIDTH'(4);
                            state_d    = S_HOLD;
                        end
                    end else if (branch_taken) begin
                        pc_d      = target;
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc_d       = target;
                        req_addr_d = target;
                        state_d    = S_FETCH;
                    end else if (decode_ready) begin
                        req_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_FETCH: mem_req     = 1'b1;
            S_HOLD:  instr_valid = 1'b1;
            default: ;
        endcase
        mem_addr    = req_addr_q;
        instruction = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table plus directed sequences, decoder-side scoreboard.
module tb_instruction_fetch;
    localparam int AW  = 17;
    localparam int LEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, chip_enabled, mem_req, mem_ready;
    logic            instr_valid, decode_ready, branch_taken;
    logic [AW-1:0]   mem_addr, instr_pc, branch_target;
    logic [LEN-1:0]  mem_data, instruction;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_n  = 0;
    int wcnt    = 0;
    logic [AW-1:0] exp_q[$];

    instruction_fetch #(.ADDR_WIDTH(AW), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .chip_enabled(chip_enabled),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
        .decode_ready(decode_ready), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    function automatic logic [LEN-1:0] word(input logic [AW-1:0] a);
        return {a, 15'h1234};
    endfunction

    // Memory model: answers after wait_n wait cycles of an outstanding request.
    always @(posedge clk) begin
        if (!rst_n || !mem_req) wcnt <= 0;
        else if (chip_enabled) wcnt <= mem_ready ? 0 : wcnt + 1;
    end
    assign mem_ready = mem_req && (wcnt >= wait_n);
    assign mem_data  = word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [AW-1:0] addr,
                           input logic vld, input logic [AW-1:0] pc);
        chk({tag, "_req"}, 32'(mem_req), 32'(req));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_vld"}, 32'(instr_valid), 32'(vld));
        chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    endtask

    // Decoder-side scoreboard: every accepted instruction must be the next expected PC.
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && chip_enabled && instr_valid && decode_ready && !branch_taken) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL hs_unexpected: got pc %h expected no handshake", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("hs_pc", 32'(instr_pc), 32'(e));
                    chk("hs_instr", instruction, word(e));
                end
            end
        end
    end

    typedef struct packed {
        logic          dr;
        logic          br;
        logic [AW-1:0] tgt;
        int            wt;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_vld;
        logic [AW-1:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic br, input logic [AW-1:0] tgt, input int wt,
                                input logic e_req, input logic [AW-1:0] e_addr,
                                input logic e_vld, input logic [AW-1:0] e_pc);
        vec_t v;
        v.dr = dr; v.br = br; v.tgt = tgt; v.wt = wt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t vt[18];

    initial begin
        vt[0]  = mk(1, 0, 17'h0,     0, 1, 17'h0,   0, 17'h0);
        vt[1]  = mk(1, 0, 17'h0,     0, 0, 17'h0,   1, 17'h0);
        vt[2]  = mk(1, 0, 17'h0,     0, 1, 17'h4,   0, 17'h0);
        vt[3]  = mk(1, 0, 17'h0,     0, 0, 17'h4,   1, 17'h4);
        vt[4]  = mk(1, 0, 17'h0,     0, 1, 17'h8,   0, 17'h4);
        vt[5]  = mk(1, 0, 17'h0,     0, 0, 17'h8,   1, 17'h8);
        vt[6]  = mk(0, 0, 17'h0,     0, 0, 17'h8,   1, 17'h8);
        vt[7]  = mk(1, 1, 17'h103,   3, 1, 17'h100, 0, 17'h8);
        vt[8]  = mk(1, 0, 17'h0,     3, 1, 17'h100, 0, 17'h8);
        vt[9]  = mk(1, 1, 17'h200,   3, 1, 17'h100, 0, 17'h8);
        vt[10] = mk(1, 0, 17'h0,     3, 1, 17'h100, 0, 17'h8);
        vt[11] = mk(1, 0, 17'h0,     3, 1, 17'h200, 0, 17'h8);
        vt[12] = mk(1, 1, 17'h300,   0, 1, 17'h300, 0, 17'h8);
        vt[13] = mk(1, 0, 17'h0,     3, 1, 17'h300, 0, 17'h8);
        vt[14] = mk(1, 0, 17'h0,     3, 1, 17'h300, 0, 17'h8);
        vt[15] = mk(1, 0, 17'h0,     3, 1, 17'h300, 0, 17'h8);
        vt[16] = mk(1, 0, 17'h0,     3, 0, 17'h300, 1, 17'h300);
        vt[17] = mk(1, 0, 17'h0,     3, 1, 17'h304, 0, 17'h300);

        rst_n = 1'b0; chip_enabled = 1'b0; decode_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0; wait_n = 0;
        tick(); tick();
        chk_out("reset", 0, 17'h0, 0, 17'h0);
        chk("reset_instr", instruction, 32'h0);

        rst_n = 1'b1;
        tick();
        chk("disabled_idle_req", 32'(mem_req), 32'h0);

        chip_enabled = 1'b1;
        exp_q.push_back(17'h0);
        exp_q.push_back(17'h4);
        exp_q.push_back(17'h300);
        for (int i = 0; i < 18; i++) begin
            decode_ready  = vt[i].dr;
            branch_taken  = vt[i].br;
            branch_target = vt[i].tgt;
            wait_n        = vt[i].wt;
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_vld, vt[i].e_pc);
        end
        branch_taken = 1'b0;
        chk("vec_sb_drained", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a request, with memory ready at that very edge.
        wait_n = 0;
        rst_n  = 1'b0;
        tick();
        chk_out("midreset", 0, 17'h0, 0, 17'h0);
        chk("midreset_instr", instruction, 32'h0);
        rst_n = 1'b1;
        tick();
        chk_out("refetch", 1, 17'h0, 0, 17'h0);

        // Redirect to the top word, then check the PC wraps to zero.
        branch_taken = 1'b1; branch_target = 17'h1FFFC;
        tick();
        chk_out("wrap_br", 1, 17'h1FFFC, 0, 17'h0);
        branch_taken = 1'b0;
        exp_q.push_back(17'h1FFFC);
        decode_ready = 1'b1;
        tick();
        chk_out("wrap_hold", 0, 17'h1FFFC, 1, 17'h1FFFC);
        tick();
        chk_out("wrap_next", 1, 17'h0, 0, 17'h1FFFC);

        // Decoder stall in HOLD.
        decode_ready = 1'b0;
        tick();
        chk_out("stall_enter", 0, 17'h0, 1, 17'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("stall%0d", i), 0, 17'h0, 1, 17'h0);
            chk($sformatf("stall%0d_instr", i), instruction, word(17'h0));
        end
        exp_q.push_back(17'h0);
        decode_ready = 1'b1;
        tick();
        chk_out("stall_release", 1, 17'h4, 0, 17'h0);

        // Freeze mid-FETCH with a branch pulse that must be ignored.
        decode_ready = 1'b0;
        wait_n = 3;
        tick();
        chk_out("frz_pre", 1, 17'h4, 0, 17'h0);
        chip_enabled = 1'b0; branch_taken = 1'b1; branch_target = 17'h40; decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("frz%0d", i), 1, 17'h4, 0, 17'h0);
        end
        chip_enabled = 1'b1; branch_taken = 1'b0; decode_ready = 1'b0;
        tick();
        chk_out("frz_w0", 1, 17'h4, 0, 17'h0);
        tick();
        chk_out("frz_w1", 1, 17'h4, 0, 17'h0);
        tick();
        chk_out("frz_done", 0, 17'h4, 1, 17'h4);

        // Freeze in HOLD: decode_ready is not a handshake while disabled.
        chip_enabled = 1'b0; decode_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("frzhold%0d", i), 0, 17'h4, 1, 17'h4);
        end
        exp_q.push_back(17'h4);
        chip_enabled = 1'b1;
        tick();
        chk_out("frzhold_go", 1, 17'h8, 0, 17'h4);
        decode_ready = 1'b0;
        tick();
        chk("final_sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the decoder. Holds the program counter, issues one word read per instruction to instruction memory over a req/ready handshake, and presents the fetched word with its PC to the decoder over a valid/ready handshake. Taken-branch redirects from execute discard any in-flight or held instruction and restart fetch at the target.

## Interface
- ADDR_WIDTH, 17, byte-address width of instruction memory
- LEN, 32, instruction width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- chip_enabled  in  1  global enable; low = freeze all state
- mem_req  out  1  read request to instruction memory
- mem_addr  out  ADDR_WIDTH  request byte address, word aligned
- mem_ready  in  1  memory returns mem_data this cycle; ignored when mem_req low
- mem_data  in  LEN  instruction word, valid when mem_req && mem_ready
- instr_valid  out  1  instruction/instr_pc valid to decoder
- instruction  out  LEN  fetched word
- instr_pc  out  ADDR_WIDTH  address of fetched word
- decode_ready  in  1  decoder accepts instruction this cycle
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  ADDR_WIDTH  redirect address; bits [1:0] forced to 0

## Operation
- Registers: pc (next fetch address), req_addr (drives mem_addr), discard flag, state.
- States IDLE, FETCH, HOLD.
- IDLE: mem_req=0. If chip_enabled: req_addr<=pc, go FETCH. branch_taken in IDLE: pc<=target, then proceed as above with the new pc (target used as req_addr that same edge).
- FETCH: mem_req=1, mem_addr=req_addr held stable until the cycle mem_ready=1 (transaction completes that cycle; never withdrawn early).
  - mem_ready && !discard && !branch_taken: instruction<=mem_data, instr_pc<=req_addr, instr_valid<=1, pc<=req_addr+4, go HOLD.
  - mem_ready && (discard || branch_taken): data dropped, discard<=0, req_addr<=(branch_taken ? target : pc), pc<=same value, stay FETCH (new request next cycle).
  - !mem_ready && branch_taken: pc<=target, discard<=1, stay FETCH, address unchanged.
- HOLD: instr_valid=1, mem_req=0.
  - branch_taken (priority over decode_ready): instr_valid<=0, pc<=target, req_addr<=target, go FETCH; instruction dropped even if decode_ready high.
  - decode_ready: instr_valid<=0, req_addr<=pc, go FETCH.
  - else hold all outputs.
- chip_enabled=0 (any state): no register changes; outputs hold; mem_req stays as is; handshakes on mem_ready/decode_ready/branch_taken ignored that cycle.
- pc arithmetic modulo 2^ADDR_WIDTH (0x1FFFC + 4 = 0x00000 at default width).

## Timing
- Reset (rst_n=0 at edge): state=IDLE, pc=0, req_addr=0, discard=0, mem_req=0, mem_addr=0, instr_valid=0, instruction=0, instr_pc=0. Reset wins over all inputs, including mid-transaction; a mem_ready arriving after reset is ignored (mem_req low).
- First request: mem_req high in the cycle after the first enabled edge out of reset.
- mem_ready may arrive in the first mem_req cycle; instr_valid rises the next cycle (1-cycle fetch latency beyond memory latency).
- Decoder handshake at edge with instr_valid && decode_ready; next mem_req the following cycle. Peak rate: one instruction per 2 cycles with zero-wait memory.
- Redirect: first request to target appears the cycle after branch_taken (HOLD) or after completion of the in-flight transaction (FETCH).
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then chip_enabled=1, zero-wait memory, decode_ready=1: mem_addr 0x0,0x4,0x8 on alternate cycles; instr_pc matches, instruction equals mem_data per address.
- Memory with 3 wait cycles: mem_addr 0x4 held stable 4 cycles; instr_valid rises exactly one cycle after mem_ready.
- decode_ready=0 for 5 cycles in HOLD: instruction/instr_pc/instr_valid stable, mem_req=0; release -> next fetch at instr_pc+4.
- branch_taken to 0x100 in FETCH during wait: current data dropped (instr_valid never rises), next mem_addr=0x100; also branch_taken and mem_ready same cycle -> same result; branch_target 0x103 -> 0x100.
- branch_taken with decode_ready in HOLD: no handshake counted, next mem_addr=target; chip_enabled low 3 cycles mid-FETCH freezes all outputs.
- rst_n low mid-transaction then high: all outputs zero, refetch from 0x0; pc at 0x1FFFC wraps to 0x0.
